ic_bvudiv_skolem_seq: RTL and testbench



---
 rtl/ic_bvudiv_skolem_seq.sv | 205 ++++++++++++++++++++
 tb/tb_ic_bvudiv_skolem_seq.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ic_bvudiv_skolem_seq.sv
// ic_bvudiv_skolem_seq -- sequential bvudiv/bvugt invertibility-condition unit.
// Decides the IC of one of two literals and emits a Skolem witness:
//   op_mode 0 : exists x. (x udiv s) >u t
//   op_mode 1 : exists x. (s udiv x) >u t
// A single restoring divider (1 quotient bit per cycle, MSB first) computes the
// quotient. Division by zero yields all-ones naturally, so latency is constant.
// Optional macro SKOLEM_VERIFY_EN adds a VERIFY pass that re-divides with the
// witness and reports the result on out_chk.
module ic_bvudiv_skolem_seq #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op_mode,
  input  logic [W-1:0] op_s,
  input  logic [W-1:0] op_t,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_ic,
  output logic [W-1:0] out_x,
  output logic         out_chk
);

  localparam logic [W-1:0]  ALL1 = '1;
  localparam logic [W-1:0]  ONE  = W'(1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_DECIDE,
    S_VERIFY,
    S_RESP
  } state_t;

  state_t r_state, w_state_nxt;

  // Latched request
  logic         r_mode;
  logic [W-1:0] r_s;
  logic [W-1:0] r_t;

  // Divider: r_dq shifts the dividend out of its MSB and the quotient into its LSB
  logic [W-1:0]  r_dq;
  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_dvs;
  logic [CW-1:0] r_cnt;

  logic [W:0]   w_trial;
  logic [W:0]   w_diff;
  logic         w_ge;
  logic [W-1:0] w_rem_nxt;
  logic [W-1:0] w_dq_nxt;
  logic         w_step_last;

  logic         w_dec_ic;
  logic [W-1:0] w_dec_x;
  logic         w_accept;

  // Response registers
  logic         r_out_ic;
  logic [W-1:0] r_out_x;

`ifdef SKOLEM_VERIFY_EN
  logic         r_ic;
  logic [W-1:0] r_x;
  logic         r_out_chk;
`endif

  assign w_accept    = in_valid && (r_state == S_IDLE);
  assign w_step_last = (r_cnt == LAST);

  // One restoring-division step: trial-subtract the divisor from the shifted remainder
  always_comb begin
    w_trial   = {r_rem, r_dq[W-1]};
    w_diff    = w_trial - {1'b0, r_dvs};
    w_ge      = (w_trial >= {1'b0, r_dvs});
    w_rem_nxt = w_ge ? w_diff[W-1:0] : w_trial[W-1:0];
    w_dq_nxt  = {r_dq[W-2:0], w_ge};
  end

  // Decision and witness from the CALC quotient (held in r_dq after W steps)
  always_comb begin
    if (!r_mode) begin
      w_dec_ic = (r_dq > r_t);
      w_dec_x  = w_dec_ic ? ALL1 : '0;
    end else begin
      w_dec_ic = (r_t != ALL1);
      w_dec_x  = (w_dec_ic && (r_s > r_t)) ? ONE : '0;
    end
  end

  // FSM state register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state logic
  // NOTE: the default assignment first keeps this block purely combinational (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept)    w_state_nxt = S_CALC;
      S_CALC:   if (w_step_last) w_state_nxt = S_DECIDE;
`ifdef SKOLEM_VERIFY_EN
      S_DECIDE:                  w_state_nxt = S_VERIFY;
      S_VERIFY: if (w_step_last) w_state_nxt = S_RESP;
`else
      S_DECIDE:                  w_state_nxt = S_RESP;
`endif
      S_RESP:   if (out_ready)   w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  // Request latch, divider load and divider stepping
  // NOTE: the divider registers are plain flops, not a RAM, so they take the async reset too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= 1'b0;
      r_s    <= '0;
      r_t    <= '0;
      r_dq   <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
`ifdef SKOLEM_VERIFY_EN
      r_ic   <= 1'b0;
      r_x    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mode <= op_mode;
            r_s    <= op_s;
            r_t    <= op_t;
            r_rem  <= '0;
            r_cnt  <= '0;
            // mode 0: ALL1 udiv s ; mode 1: s udiv 1 (latency filler)
            r_dq   <= op_mode ? op_s : ALL1;
            r_dvs  <= op_mode ? ONE  : op_s;
          end
        end
        S_CALC, S_VERIFY: begin
          r_rem <= w_rem_nxt;
          r_dq  <= w_dq_nxt;
          r_cnt <= r_cnt + CW'(1);
        end
`ifdef SKOLEM_VERIFY_EN
        S_DECIDE: begin
          r_ic  <= w_dec_ic;
          r_x   <= w_dec_x;
          r_rem <= '0;
          r_cnt <= '0;
          // mode 0: x udiv s ; mode 1: s udiv x
          r_dq  <= r_mode ? r_s     : w_dec_x;
          r_dvs <= r_mode ? w_dec_x : r_s;
        end
`endif
        default: ;
      endcase
    end
  end

  // Response registers, loaded only on the edge that enters RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_ic  <= 1'b0;
      r_out_x   <= '0;
`ifdef SKOLEM_VERIFY_EN
      r_out_chk <= 1'b0;
`endif
    end else begin
`ifdef SKOLEM_VERIFY_EN
      if (r_state == S_VERIFY && w_step_last) begin
        r_out_ic  <= r_ic;
        r_out_x   <= r_x;
        r_out_chk <= r_ic ? (w_dq_nxt > r_t) : 1'b1;
      end
`else
      if (r_state == S_DECIDE) begin
        r_out_ic <= w_dec_ic;
        r_out_x  <= w_dec_x;
      end
`endif
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_RESP);
  assign out_ic    = r_out_ic;
  assign out_x     = r_out_x;
`ifdef SKOLEM_VERIFY_EN
  assign out_chk   = r_out_chk;
`else
  assign out_chk   = (r_state == S_RESP);
`endif

endmodule

// File: tb/tb_ic_bvudiv_skolem_seq.sv
// tb_ic_bvudiv_skolem_seq -- scoreboard bench for ic_bvudiv_skolem_seq.
// Two instances: W=8 for directed/random scenarios, W=4 for the exhaustive sweep.
// Expected ic comes from a brute-force exists-x search; latency follows SKOLEM_VERIFY_EN.
module tb_ic_bvudiv_skolem_seq;

  localparam int W8 = 8;
  localparam int W4 = 4;
`ifdef SKOLEM_VERIFY_EN
  localparam int LAT8 = 2 * W8 + 2;
  localparam int LAT4 = 2 * W4 + 2;
`else
  localparam int LAT8 = W8 + 2;
  localparam int LAT4 = W4 + 2;
`endif

  typedef struct packed {
    logic       ic;
    logic [7:0] x;
    logic       chk;
    int         acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic          d8_in_valid = 1'b0, d8_in_ready, d8_op_mode = 1'b0;
  logic [W8-1:0] d8_op_s = '0, d8_op_t = '0, d8_out_x;
  logic          d8_out_valid, d8_out_ready = 1'b0, d8_out_ic, d8_out_chk;

  logic          d4_in_valid = 1'b0, d4_in_ready, d4_op_mode = 1'b0;
  logic [W4-1:0] d4_op_s = '0, d4_op_t = '0, d4_out_x;
  logic          d4_out_valid, d4_out_ready = 1'b0, d4_out_ic, d4_out_chk;

  ic_bvudiv_skolem_seq #(.W(W8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d8_in_valid), .in_ready(d8_in_ready),
    .op_mode(d8_op_mode), .op_s(d8_op_s), .op_t(d8_op_t),
    .out_valid(d8_out_valid), .out_ready(d8_out_ready),
    .out_ic(d8_out_ic), .out_x(d8_out_x), .out_chk(d8_out_chk)
  );

  ic_bvudiv_skolem_seq #(.W(W4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d4_in_valid), .in_ready(d4_in_ready),
    .op_mode(d4_op_mode), .op_s(d4_op_s), .op_t(d4_op_t),
    .out_valid(d4_out_valid), .out_ready(d4_out_ready),
    .out_ic(d4_out_ic), .out_x(d4_out_x), .out_chk(d4_out_chk)
  );

  exp_t sb8[$];
  exp_t sb4[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // SMT-LIB unsigned division on a w-bit value held in 8 bits
  function automatic logic [7:0] udiv(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] all1);
    return (b == 8'd0) ? all1 : (a / b);
  endfunction

  // Brute-force IC over every x, witness per the decision rules
  function automatic exp_t model(input logic mode, input logic [7:0] s,
                                 input logic [7:0] t, input int w);
    exp_t       e;
    logic [7:0] all1;
    logic [7:0] r;
    all1 = 8'((1 << w) - 1);
    e.ic = 1'b0;
    for (int x = 0; x < (1 << w); x++) begin
      r = mode ? udiv(s, 8'(x), all1) : udiv(8'(x), s, all1);
      if (r > t) e.ic = 1'b1;
    end
    if (!e.ic)     e.x = 8'd0;
    else if (mode) e.x = (s > t) ? 8'd1 : 8'd0;
    else           e.x = all1;
    e.chk = 1'b1;
    e.acc = 0;
    return e;
  endfunction

  // Drive one W=8 request and push its expectation once accepted
  task automatic issue8(input logic mode, input logic [7:0] s, input logic [7:0] t);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    d8_op_mode = mode; d8_op_s = s; d8_op_t = t; d8_in_valid = 1'b1;
    while (!d8_in_ready && n < 100) begin @(negedge clk); n++; end
    if (!d8_in_ready) begin
      n_vec++; n_miss++;
      $display("FAIL accept8: in_ready=%b after %0d cycles, required 1", d8_in_ready, n);
      d8_in_valid = 1'b0;
      return;
    end
    e = model(mode, s, t, W8);
    e.acc = cyc;
    sb8.push_back(e);
    @(negedge clk);
    d8_in_valid = 1'b0;
  endtask

  // Wait for a W=8 response, pop and compare, hold backpressure, then handshake
  task automatic drain8(input int hold);
    exp_t       e;
    int         n;
    logic       ic0, chk0;
    logic [7:0] x0;
    n = 0;
    while (!d8_out_valid && n < 200) begin @(negedge clk); n++; end
    n_vec++;
    if (!d8_out_valid || sb8.size() == 0) begin
      n_miss++;
      $display("FAIL resp8: out_valid=%b queued=%0d, required a response", d8_out_valid, sb8.size());
      return;
    end
    e = sb8.pop_front();
    if ((cyc - e.acc) != LAT8) begin
      n_miss++; $display("FAIL lat8: got %0d required %0d", cyc - e.acc, LAT8);
    end
    n_vec++;
    if (d8_out_ic !== e.ic) begin
      n_miss++; $display("FAIL ic8: got %b required %b", d8_out_ic, e.ic);
    end
    n_vec++;
    if (d8_out_x !== e.x) begin
      n_miss++; $display("FAIL x8: got %h required %h", d8_out_x, e.x);
    end
    n_vec++;
    if (d8_out_chk !== e.chk) begin
      n_miss++; $display("FAIL chk8: got %b required %b", d8_out_chk, e.chk);
    end
    ic0 = e.ic; x0 = e.x; chk0 = e.chk;
    repeat (hold) begin
      @(negedge clk);
      n_vec++;
      if (d8_out_valid !== 1'b1 || d8_in_ready !== 1'b0 || d8_out_ic !== ic0 ||
          d8_out_x !== x0 || d8_out_chk !== chk0) begin
        n_miss++;
        $display("FAIL hold8: valid=%b ready=%b ic=%b x=%h chk=%b required 1 0 %b %h %b",
                 d8_out_valid, d8_in_ready, d8_out_ic, d8_out_x, d8_out_chk, ic0, x0, chk0);
      end
    end
    d8_out_ready = 1'b1;
    @(negedge clk);
    d8_out_ready = 1'b0;
    n_vec++;
    if (d8_out_valid !== 1'b0) begin
      n_miss++; $display("FAIL release8: out_valid=%b required 0", d8_out_valid);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (d8_in_ready !== 1'b1) begin n_miss++; $display("FAIL rst_in_ready: got %b required 1", d8_in_ready); end
    n_vec++;
    if (d8_out_valid !== 1'b0) begin n_miss++; $display("FAIL rst_out_valid: got %b required 0", d8_out_valid); end
    n_vec++;
    if (d8_out_ic !== 1'b0) begin n_miss++; $display("FAIL rst_out_ic: got %b required 0", d8_out_ic); end
    n_vec++;
    if (d8_out_x !== 8'h00) begin n_miss++; $display("FAIL rst_out_x: got %h required 00", d8_out_x); end
    n_vec++;
    if (d8_out_chk !== 1'b0) begin n_miss++; $display("FAIL rst_out_chk: got %b required 0", d8_out_chk); end
    n_vec++;
    if ({d4_in_ready, d4_out_valid, d4_out_ic, d4_out_x, d4_out_chk} !== 8'b1000_0000) begin
      n_miss++;
      $display("FAIL rst_d4: got %b required 10000000",
               {d4_in_ready, d4_out_valid, d4_out_ic, d4_out_x, d4_out_chk});
    end
  endtask

  task automatic test_mode0;
    issue8(1'b0, 8'd3, 8'd84);   drain8(0);
    issue8(1'b0, 8'd3, 8'd85);   drain8(0);
    issue8(1'b0, 8'd0, 8'hFE);   drain8(0);
    issue8(1'b0, 8'd0, 8'hFF);   drain8(0);
    issue8(1'b0, 8'd1, 8'hFE);   drain8(0);
  endtask

  task automatic test_mode1;
    issue8(1'b1, 8'd10, 8'd9);   drain8(0);
    issue8(1'b1, 8'd5,  8'd9);   drain8(0);
    issue8(1'b1, 8'd7,  8'hFF);  drain8(0);
    issue8(1'b1, 8'd0,  8'd0);   drain8(0);
    for (int i = 0; i < 8; i++) begin
      issue8(1'(i & 1), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      drain8(0);
    end
  endtask

  // Held request during busy must be taken exactly one cycle after the handshake
  task automatic test_back_to_back;
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    d8_op_mode = 1'b0; d8_op_s = 8'd7; d8_op_t = 8'd20; d8_in_valid = 1'b1;
    while (!d8_in_ready && n < 100) begin @(negedge clk); n++; end
    e = model(1'b0, 8'd7, 8'd20, W8);
    e.acc = cyc;
    sb8.push_back(e);
    @(negedge clk);
    d8_op_mode = 1'b1; d8_op_s = 8'd200; d8_op_t = 8'd100;
    n_vec++;
    if (d8_in_ready !== 1'b0) begin n_miss++; $display("FAIL busy_ready: got %b required 0", d8_in_ready); end
    drain8(5);
    n_vec++;
    if (d8_in_ready !== 1'b1) begin n_miss++; $display("FAIL reaccept_ready: got %b required 1", d8_in_ready); end
    e = model(1'b1, 8'd200, 8'd100, W8);
    e.acc = cyc;
    sb8.push_back(e);
    @(negedge clk);
    d8_in_valid = 1'b0;
    drain8(0);
  endtask

  // Reset in CALC cycle 3 aborts silently; the next request is unaffected
  task automatic test_reset_abort;
    int   n;
    logic seen;
    n = 0;
    @(negedge clk);
    d8_op_mode = 1'b0; d8_op_s = 8'd3; d8_op_t = 8'd10; d8_in_valid = 1'b1;
    while (!d8_in_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 d8_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (d8_out_valid !== 1'b0 || d8_in_ready !== 1'b1) begin
      n_miss++;
      $display("FAIL abort_async: valid=%b ready=%b required 0 1", d8_out_valid, d8_in_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (d8_out_valid) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin n_miss++; $display("FAIL abort_stale: out_valid seen=%b required 0", seen); end
    n_vec++;
    if (d8_out_ic !== 1'b0 || d8_out_x !== 8'h00) begin
      n_miss++; $display("FAIL abort_outs: ic=%b x=%h required 0 00", d8_out_ic, d8_out_x);
    end
    issue8(1'b0, 8'd3, 8'd84);
    drain8(0);
  endtask

  // Every s, t in both modes at W=4
  task automatic test_exhaustive4;
    exp_t e;
    int   n;
    for (int m = 0; m < 2; m++) begin
      for (int s = 0; s < 16; s++) begin
        for (int t = 0; t < 16; t++) begin
          n = 0;
          @(negedge clk);
          d4_op_mode = 1'(m); d4_op_s = 4'(s); d4_op_t = 4'(t); d4_in_valid = 1'b1;
          while (!d4_in_ready && n < 100) begin @(negedge clk); n++; end
          e = model(1'(m), 8'(s), 8'(t), W4);
          e.acc = cyc;
          sb4.push_back(e);
          @(negedge clk);
          d4_in_valid = 1'b0;
          n = 0;
          while (!d4_out_valid && n < 100) begin @(negedge clk); n++; end
          n_vec++;
          if (!d4_out_valid) begin
            n_miss++;
            $display("FAIL resp4: m=%0d s=%0d t=%0d no response", m, s, t);
            void'(sb4.pop_front());
            continue;
          end
          e = sb4.pop_front();
          if ((cyc - e.acc) != LAT4) begin
            n_miss++; $display("FAIL lat4: m=%0d s=%0d t=%0d got %0d required %0d", m, s, t, cyc - e.acc, LAT4);
          end
          n_vec++;
          if (d4_out_ic !== e.ic) begin
            n_miss++; $display("FAIL ic4: m=%0d s=%0d t=%0d got %b required %b", m, s, t, d4_out_ic, e.ic);
          end
          n_vec++;
          if ({4'h0, d4_out_x} !== e.x) begin
            n_miss++; $display("FAIL x4: m=%0d s=%0d t=%0d got %h required %h", m, s, t, d4_out_x, e.x);
          end
          n_vec++;
          if (d4_out_chk !== e.chk) begin
            n_miss++; $display("FAIL chk4: m=%0d s=%0d t=%0d got %b required %b", m, s, t, d4_out_chk, e.chk);
          end
          d4_out_ready = 1'b1;
          @(negedge clk);
          d4_out_ready = 1'b0;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode1();
    test_back_to_back();
    test_reset_abort();
    test_exhaustive4();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
